// File: rtl/multi_channel_debounce.sv
// multi_channel_debounce
//   NUM_CH pushbutton debouncers sharing one millisecond sample prescaler.
//   Each channel: 2-flop synchroniser, optional polarity inversion, then a
//   stable-count filter that commits a new level only after DEBOUNCE_MS
//   consecutive differing ticks. Rise/fall strobes are registered alongside
//   the level so they appear in the same clk the level changes.
//   Optional feature macro: LONG_PRESS_EN adds a per-channel hold counter
//   and a one-shot btn_long strobe; without it btn_long is tied low.
module multi_channel_debounce #(
    parameter int NUM_CH      = 4,
    parameter int CLK_PER_MS  = 100000,
    parameter int DEBOUNCE_MS = 25,
    parameter int ACTIVE_LOW  = 0,
    parameter int LONG_MS     = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn,
    output logic [NUM_CH-1:0] btn_level,
    output logic [NUM_CH-1:0] btn_rise,
    output logic [NUM_CH-1:0] btn_fall,
    output logic [NUM_CH-1:0] btn_long
);

    // Prescaler width; a divide-by-1 prescaler still needs a 1-bit counter.
    localparam int TW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int CW = $clog2(DEBOUNCE_MS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_PER_MS - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_MS - 1);
    localparam logic          POL       = (ACTIVE_LOW != 0);

    logic [TW-1:0]     tick_cnt_reg;
    logic              tick;
    logic [NUM_CH-1:0] s1_reg;
    logic [NUM_CH-1:0] s2_reg;
    logic [NUM_CH-1:0] in_w;

    assign tick = (tick_cnt_reg == TICK_LAST);
    assign in_w = s2_reg ^ {NUM_CH{POL}};

    // Shared sample prescaler: counts 0..CLK_PER_MS-1, tick on the last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    // Two-flop synchroniser for the raw asynchronous button pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= btn;
            s2_reg <= s1_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CW-1:0] cnt_reg;
            logic          level_reg;
            logic          rise_reg;
            logic          fall_reg;

            // Stable-count filter: any sample matching the current level
            // restarts the count; DEBOUNCE_MS differing ticks commit the change.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                    rise_reg  <= 1'b0;
                    fall_reg  <= 1'b0;
                end else begin
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                    if (in_w[gi] == level_reg) begin
                        cnt_reg <= '0;
                    end else if (tick) begin
                        if (cnt_reg == CNT_LAST) begin
                            level_reg <= in_w[gi];
                            cnt_reg   <= '0;
                            rise_reg  <= in_w[gi];
                            fall_reg  <= ~in_w[gi];
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
            end

            assign btn_level[gi] = level_reg;
            assign btn_rise[gi]  = rise_reg;
            assign btn_fall[gi]  = fall_reg;

`ifdef LONG_PRESS_EN
            localparam int LW = $clog2(LONG_MS + 1);
            localparam logic [LW-1:0] HOLD_MAX = LW'(LONG_MS);

            logic [LW-1:0] hold_reg;
            logic          long_reg;

            // Hold timer: runs on ticks while pressed, saturates, and fires
            // its strobe only on the tick that reaches LONG_MS.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hold_reg <= '0;
                    long_reg <= 1'b0;
                end else begin
                    long_reg <= 1'b0;
                    if (!level_reg) begin
                        hold_reg <= '0;
                    end else if (tick && (hold_reg != HOLD_MAX)) begin
                        hold_reg <= hold_reg + 1'b1;
                        if (hold_reg == HOLD_MAX - 1'b1) begin
                            long_reg <= 1'b1;
                        end
                    end
                end
            end

            assign btn_long[gi] = long_reg;
`else
            assign btn_long[gi] = 1'b0;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_multi_channel_debounce.sv
// tb_multi_channel_debounce
//   Directed scenarios followed by randomised button activity, all checked
//   every clk against a behavioural model built from the debounce rules:
//   ticks are every CPM-th edge after reset release, the filter input is the
//   button value from two edges earlier, and per-channel integers track the
//   run of differing ticks and the hold time. Honours LONG_PRESS_EN.
module tb_multi_channel_debounce;

    localparam int NCH = 4;
    localparam int CPM = 4;
    localparam int DEB = 3;
    localparam int LMS = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] btn = '0;
    logic [NCH-1:0] btn_level;
    logic [NCH-1:0] btn_rise;
    logic [NCH-1:0] btn_fall;
    logic [NCH-1:0] btn_long;

    multi_channel_debounce #(
        .NUM_CH(NCH), .CLK_PER_MS(CPM), .DEBOUNCE_MS(DEB),
        .ACTIVE_LOW(0), .LONG_MS(LMS)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn),
        .btn_level(btn_level), .btn_rise(btn_rise),
        .btn_fall(btn_fall), .btn_long(btn_long)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int             edge_n;
    logic [NCH-1:0] hist[$];
    int             run_m[NCH];
    int             hold_m[NCH];
    logic [NCH-1:0] lvl_m, rise_m, fall_m, long_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        edge_n = 0;
        hist.delete();
        lvl_m = '0; rise_m = '0; fall_m = '0; long_m = '0;
        for (int c = 0; c < NCH; c++) begin
            run_m[c]  = 0;
            hold_m[c] = 0;
        end
    endtask

    // One rising clk edge with reset released, b = button value at that edge.
    task automatic model_edge(input logic [NCH-1:0] b);
        logic [NCH-1:0] in_v;
        logic [NCH-1:0] old_lvl;
        bit tick;
        edge_n++;
        tick = ((edge_n % CPM) == 0);
        in_v = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
        hist.push_back(b);
        if (hist.size() > 3) void'(hist.pop_front());
        old_lvl = lvl_m;
        rise_m = '0; fall_m = '0; long_m = '0;
        for (int c = 0; c < NCH; c++) begin
`ifdef LONG_PRESS_EN
            if (!old_lvl[c]) hold_m[c] = 0;
            else if (tick && hold_m[c] < LMS) begin
                hold_m[c]++;
                if (hold_m[c] == LMS) long_m[c] = 1'b1;
            end
`endif
            if (in_v[c] == old_lvl[c]) run_m[c] = 0;
            else if (tick) begin
                run_m[c]++;
                if (run_m[c] == DEB) begin
                    lvl_m[c]  = in_v[c];
                    run_m[c]  = 0;
                    rise_m[c] = in_v[c];
                    fall_m[c] = ~in_v[c];
                end
            end
        end
    endtask

    task automatic compare_all();
        check("level", 32'(btn_level), 32'(lvl_m));
        check("rise",  32'(btn_rise),  32'(rise_m));
        check("fall",  32'(btn_fall),  32'(fall_m));
        check("long",  32'(btn_long),  32'(long_m));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst) model_edge(btn);
        #1;
        compare_all();
    endtask

    // Asynchronous reset asserted between edges, held for n edges.
    task automatic pulse_reset(input int n);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        repeat (n) cyc();
        #2;
        rst = 1'b0;
    endtask

    int lat;
    bit found;
    int long_seen;
    int seg_p;

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        // 1: reset with all buttons pressed, release with buttons low
        btn = 4'hF;
        #3;
        compare_all();
        repeat (3) cyc();
        #2;
        btn = 4'h0;
        rst = 1'b0;
        cyc();

        // 2: single press on channel 0, latency window
        btn[0] = 1'b1;
        lat = 0; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            lat++;
            if (btn_level[0]) found = 1;
        end
        check("press0_latency_10_14", 32'(found && lat >= 10 && lat <= 14), 32'd1);
        repeat (4) cyc();

        // 3: channel 1 bouncing every 5 clk for 60 clk
        for (int i = 0; i < 12; i++) begin
            btn[1] = ~btn[1];
            repeat (5) cyc();
        end
        check("bounce1_level", 32'(btn_level[1]), 32'd0);
        btn[1] = 1'b0;
        repeat (20) cyc();

        // 4: simultaneous press/release on channels 2 and 3
        btn[3:2] = 2'b11;
        repeat (20) cyc();
        btn[3:2] = 2'b00;
        repeat (20) cyc();

        // 5: reset in the middle of a pending release on channel 0
        btn[0] = 1'b0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc();
            if (run_m[0] == 2) found = 1;
        end
        check("rel0_reached_cnt2", 32'(found), 32'd1);
        btn[0] = 1'b1;
        pulse_reset(2);
        check("rst0_level", 32'(btn_level[0]), 32'd0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (btn_rise[0]) found = 1;
        end
        check("repress0_rise", 32'(found), 32'd1);
        repeat (3) cyc();

        // 6: long hold on channel 1
        btn[1] = 1'b1;
        long_seen = 0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (btn_long[1]) long_seen++;
        end
`ifdef LONG_PRESS_EN
        check("long1_count", 32'(long_seen), 32'd1);
`else
        check("long1_count", 32'(long_seen), 32'd0);
`endif
        btn[1] = 1'b0;
        repeat (20) cyc();

        // 7: random activity with varying bounce rates and occasional reset
        for (int seg = 0; seg < 8; seg++) begin
            case ($urandom_range(0, 2))
                0: seg_p = 2;
                1: seg_p = 15;
                default: seg_p = 120;
            endcase
            for (int i = 0; i < 100; i++) begin
                for (int c = 0; c < NCH; c++)
                    if ($urandom_range(0, 999) < seg_p) btn[c] = ~btn[c];
                cyc();
            end
            if ($urandom_range(0, 3) == 0) pulse_reset($urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
